store_rmw_unit: RTL and testbench

- Store-side counterpart to the load/immediate widening path: narrows a 32-bit register value into a byte or halfword and writes it into word-wide data memory.
- Data memory has no byte enables, so sub-word stores use read-modify-write: read the word, merge the lane, write it back.
- Word stores bypass the read.
- Sits between the MEM stage and data memory. The pipeline stalls on st_ready low.

---
 rtl/store_rmw_unit.sv | 161 ++++++++++++++++
 tb/tb_store_rmw_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// Store narrowing unit: writes byte/halfword/word stores into a word-wide data memory
// without byte enables, using read-modify-write for sub-word sizes.
module store_rmw_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] data_r, data_s;
  logic [1:0]  size_r, size_s;
  logic [31:0] wdata_r, wdata_s;
  logic        bad_req_s;

  // Replace the addressed lane of a memory word with the low bits of the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [4:0]  shift;
    logic [31:0] mask;
    shift = 5'd0;
    mask  = 32'hFFFF_FFFF;
    case (size)
      2'b00: begin
        mask  = 32'h0000_00FF;
        shift = BIG_ENDIAN ? (5'd24 - {lane, 3'b000}) : {lane, 3'b000};
      end
      2'b01: begin
        mask  = 32'h0000_FFFF;
        shift = (BIG_ENDIAN ^ lane[1]) ? 5'd16 : 5'd0;
      end
      default: begin
        mask  = 32'hFFFF_FFFF;
        shift = 5'd0;
      end
    endcase
    return (word & ~(mask << shift)) | ((data & mask) << shift);
  endfunction

  // Request is rejected for reserved size or a lane that straddles the word.
  always_comb begin
    bad_req_s = 1'b0;
    case (st_size)
      2'b00:   bad_req_s = 1'b0;
      2'b01:   bad_req_s = st_addr[0];
      2'b10:   bad_req_s = (st_addr[1:0] != 2'b00);
      default: bad_req_s = 1'b1;
    endcase
  end

  // Next-state and latched-operand logic.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    data_s  = data_r;
    size_s  = size_r;
    wdata_s = wdata_r;
    case (state_r)
      IDLE: begin
        if (st_valid) begin
          addr_s = st_addr;
          data_s = st_data;
          size_s = st_size;
          if (bad_req_s) begin
            state_s = ERR;
          end else if (st_size == 2'b10) begin
            wdata_s = st_data;
            state_s = WRITE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (mem_ack) begin
          wdata_s = merge_lane(mem_rdata, data_r, size_r, addr_r[1:0]);
          state_s = WRITE;
        end else begin
          state_s = READ;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and operand registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      addr_r  <= 32'h0000_0000;
      data_r  <= 32'h0000_0000;
      size_r  <= 2'b00;
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      size_r  <= size_s;
      wdata_r <= wdata_s;
    end
  end

  // Handshake outputs decode purely from the state register.
  always_comb begin
    st_ready = 1'b0;
    st_done  = 1'b0;
    st_err   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    case (state_r)
      IDLE:  st_ready = 1'b1;
      READ:  mem_req  = 1'b1;
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      DONE:    st_done = 1'b1;
      ERR:     st_err  = 1'b1;
      default: st_ready = 1'b0;
    endcase
  end

  assign mem_addr  = {addr_r[31:2], 2'b00};
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: big- and little-endian instances run in lockstep against a
// shared memory responder; expected writes are queued at issue and checked on completion.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        b_ready, b_done, b_err, b_req, b_we;
  logic [31:0] b_addr, b_wdata;
  logic        l_ready, l_done, l_err, l_req, l_we;
  logic [31:0] l_addr, l_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] mem;
    int          dly;
    logic [31:0] exp_be;
    logic [31:0] exp_le;
    bit          err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] be;
    logic [31:0] le;
  } exp_t;

  exp_t expq[$];
  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   reads = 0;
  int   req_cycles = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic ack_force = 1'b0;

  store_rmw_unit #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(b_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_done(b_done), .st_err(b_err), .mem_req(b_req), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  store_rmw_unit #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(l_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_done(l_done), .st_err(l_err), .mem_req(l_req), .mem_we(l_we),
    .mem_addr(l_addr), .mem_wdata(l_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  assign mem_ack = ack_force | (b_req && (wait_cnt == ack_delay));

  // Memory wait-state counter: acks after ack_delay cycles of a pending request.
  always @(posedge clk) begin
    if (b_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory-side monitor: stability while waiting, read address and scoreboard on writes.
  logic        pw = 1'b0;
  logic        pwe;
  logic [31:0] pa, pd;
  exp_t        e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pw = 1'b0;
      end else begin
        if (b_req) req_cycles++;
        chk("lockstep_req", 32'(l_req), 32'(b_req));
        if (pw) begin
          chk("hold_req", 32'(b_req), 32'd1);
          chk("hold_we", 32'(b_we), 32'(pwe));
          chk("hold_addr", b_addr, pa);
          chk("hold_wdata", b_wdata, pd);
        end
        if (b_req && mem_ack) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_txn we=%0d addr=%h required=none", b_we, b_addr);
          end else if (b_we) begin
            e = expq.pop_front();
            writes++;
            chk("write_addr_be", b_addr, e.addr);
            chk("write_addr_le", l_addr, e.addr);
            chk("write_data_be", b_wdata, e.be);
            chk("write_data_le", l_wdata, e.le);
          end else begin
            reads++;
            chk("read_addr", b_addr, expq[0].addr);
          end
        end
        pw  = b_req && !mem_ack;
        pwe = b_we;
        pa  = b_addr;
        pd  = b_wdata;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int c;
    int w0, r0, q0;
    bit seen;
    exp_t x;
    mem_rdata = v.mem;
    ack_delay = v.dly;
    if (!v.err) begin
      x.addr = {v.addr[31:2], 2'b00};
      x.be   = v.exp_be;
      x.le   = v.exp_le;
      expq.push_back(x);
    end
    w0 = writes;
    r0 = reads;
    q0 = req_cycles;
    @(negedge clk);
    chk("ready_before", 32'(b_ready), 32'd1);
    st_valid = 1'b1;
    st_addr  = v.addr;
    st_data  = v.data;
    st_size  = v.size;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    st_addr  = $urandom;
    st_data  = $urandom;
    st_size  = 2'b11;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 60) begin
      @(negedge clk);
      c++;
      if (b_done || b_err) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout addr=%h cycles=%0d required=%0d", v.addr, c, v.lat);
    end
    chk("latency", 32'(c), 32'(v.lat));
    chk("done_be", 32'(b_done), 32'(!v.err));
    chk("err_be", 32'(b_err), 32'(v.err));
    chk("done_le", 32'(l_done), 32'(!v.err));
    chk("err_le", 32'(l_err), 32'(v.err));
    @(negedge clk);
    chk("ready_after", 32'(b_ready), 32'd1);
    chk("pulse_done", 32'(b_done), 32'd0);
    chk("pulse_err", 32'(b_err), 32'd0);
    chk("write_count", 32'(writes - w0), v.err ? 32'd0 : 32'd1);
    chk("read_count", 32'(reads - r0), (v.err || v.size == 2'b10) ? 32'd0 : 32'd1);
    if (v.err) chk("err_no_req", 32'(req_cycles - q0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int w0, dn;
    vec_t fin;
    vecs[0]  = '{32'h0000_1001, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 0, 32'h11AB_3344, 32'h1122_AB44, 1'b0, 3};
    vecs[1]  = '{32'h0000_1002, 32'h1234_BEEF, 2'b01, 32'h1122_3344, 2, 32'h1122_BEEF, 32'hBEEF_3344, 1'b0, 7};
    vecs[2]  = '{32'h0000_1001, 32'h0000_00AB, 2'b00, 32'h1122_3344, 0, 32'h11AB_3344, 32'h1122_AB44, 1'b0, 3};
    vecs[3]  = '{32'h0000_1004, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[4]  = '{32'h0000_1003, 32'h0000_1234, 2'b01, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[5]  = '{32'h0000_1000, 32'h0000_1234, 2'b11, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[6]  = '{32'h0000_1002, 32'h0000_1234, 2'b10, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[7]  = '{32'h0000_2000, 32'h0000_0055, 2'b00, 32'hAABB_CCDD, 1, 32'h55BB_CCDD, 32'hAABB_CC55, 1'b0, 5};
    vecs[8]  = '{32'h0000_2003, 32'h0000_0077, 2'b00, 32'hAABB_CCDD, 0, 32'hAABB_CC77, 32'h77BB_CCDD, 1'b0, 3};
    vecs[9]  = '{32'h0000_2000, 32'hFFFF_0123, 2'b01, 32'hAABB_CCDD, 0, 32'h0123_CCDD, 32'hAABB_0123, 1'b0, 3};
    vecs[10] = '{32'h0000_3000, 32'h0123_4567, 2'b10, 32'h0000_0000, 1, 32'h0123_4567, 32'h0123_4567, 1'b0, 3};

    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    st_size   = 2'b00;
    mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(b_ready), 32'd1);
    chk("rst_req", 32'(b_req), 32'd0);
    chk("rst_we", 32'(b_we), 32'd0);
    chk("rst_done", 32'(b_done), 32'd0);
    chk("rst_err", 32'(b_err), 32'd0);
    chk("rst_addr", b_addr, 32'h0);
    chk("rst_wdata", b_wdata, 32'h0);
    chk("rst_ready_le", 32'(l_ready), 32'd1);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a read is outstanding, with an ack landing on the reset edge.
    mem_rdata = 32'h1122_3344;
    ack_delay = 10;
    w0 = writes;
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = 32'h0000_4001;
    st_data  = 32'h0000_0099;
    st_size  = 2'b00;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    @(negedge clk);
    chk("mid_read_req", 32'(b_req), 32'd1);
    chk("mid_read_we", 32'(b_we), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ack_force = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_force = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(b_ready), 32'd1);
    chk("abort_req", 32'(b_req), 32'd0);
    chk("abort_req_le", 32'(l_req), 32'd0);
    chk("abort_addr", b_addr, 32'h0);
    chk("abort_wdata", b_wdata, 32'h0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (b_done || l_done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_no_write", 32'(writes - w0), 32'd0);

    fin = '{32'h0000_5000, 32'hCAFE_F00D, 2'b10, 32'h0000_0000, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2};
    run_vec(fin);

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
